// File: rtl/ucsbece154_imem_arb.sv
// Instruction-memory arbiter: a demand (cache miss) port and a prefetch port share one
// burst-read memory. Demand wins by default, and a starvation counter forces a prefetch grant.
module ucsbece154_imem_arb #(
   parameter int BLOCK_WORDS  = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        p_req,
   input  logic [31:0] p_addr,
   input  logic        p_cancel,
   output logic        d_gnt,
   output logic        p_gnt,
   output logic        d_rvalid,
   output logic        p_rvalid,
   output logic        r_last,
   output logic [31:0] rdata,
   output logic        d_hit_inflight,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        mem_ready
);

   // state  | meaning
   // S_IDLE | no transfer; arbitrate and grant on the same edge
   // S_ISSUE| single-cycle mem_req with the latched address
   // S_BURST| count mem_ready beats and forward them to the owner
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BURST = 2'd2
   } state_t;

   localparam int BEAT_W   = $clog2(BLOCK_WORDS);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   state_t              state_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [STARVE_W-1:0] starve_q;
   logic                owner_p_q;
   logic                cancel_q;
   logic [31:0]         addr_q;

   logic starved;
   logic pick_p;
   logic pick_d;
   logic in_idle;
   logic in_flight;
   logic cancel_now;
   logic beat;
   logic last_beat;

   assign starved = (starve_q == STARVE_MAX) && p_req;
   assign pick_p  = p_req && (!d_req || starved);
   assign pick_d  = d_req && !pick_p;

   assign in_idle   = !reset && (state_q == S_IDLE);
   assign in_flight = (state_q == S_ISSUE) || (state_q == S_BURST);

   // Cancel takes effect in the cycle it is raised, not only from the next one.
   assign cancel_now = cancel_q || (p_cancel && owner_p_q && in_flight);

   assign beat      = !reset && (state_q == S_BURST) && mem_ready;
   assign last_beat = beat && (beat_q == LAST_BEAT);

   assign d_gnt    = in_idle && pick_d;
   assign p_gnt    = in_idle && pick_p;
   assign d_rvalid = beat && !owner_p_q;
   assign p_rvalid = beat && owner_p_q && !cancel_now;
   assign r_last   = last_beat && !(owner_p_q && cancel_now);
   assign rdata    = mem_data;

   assign mem_req  = !reset && (state_q == S_ISSUE);
   assign mem_addr = reset ? 32'd0 : addr_q;

   assign d_hit_inflight = !reset && owner_p_q && in_flight &&
                           (d_addr[31:4] == addr_q[31:4]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         beat_q    <= '0;
         starve_q  <= '0;
         owner_p_q <= 1'b0;
         cancel_q  <= 1'b0;
         addr_q    <= '0;
      end else begin
         if (!p_req || p_gnt) begin
            starve_q <= '0;
         end else if (d_gnt && (starve_q != STARVE_MAX)) begin
            starve_q <= starve_q + STARVE_W'(1);
         end

         case (state_q)
            S_IDLE: begin
               if (d_req || p_req) begin
                  addr_q    <= pick_p ? p_addr : d_addr;
                  owner_p_q <= pick_p;
                  cancel_q  <= 1'b0;
                  beat_q    <= '0;
                  state_q   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cancel_q <= cancel_now;
               state_q  <= S_BURST;
            end
            S_BURST: begin
               cancel_q <= cancel_now;
               // Memory cannot abort, so beats are counted even when delivery is cancelled.
               if (mem_ready) begin
                  beat_q <= beat_q + BEAT_W'(1);
               end
               if (last_beat) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ucsbece154_imem_arb.sv
// Bench for ucsbece154_imem_arb: per-cycle vector table plus a starvation-rotation sequence.
module tb_ucsbece154_imem_arb;

   logic        clk;
   logic        reset;
   logic        d_req;
   logic [31:0] d_addr;
   logic        p_req;
   logic [31:0] p_addr;
   logic        p_cancel;
   logic        d_gnt;
   logic        p_gnt;
   logic        d_rvalid;
   logic        p_rvalid;
   logic        r_last;
   logic [31:0] rdata;
   logic        d_hit_inflight;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_ready;

   ucsbece154_imem_arb #(.BLOCK_WORDS(4), .STARVE_LIMIT(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .d_req          (d_req),
      .d_addr         (d_addr),
      .p_req          (p_req),
      .p_addr         (p_addr),
      .p_cancel       (p_cancel),
      .d_gnt          (d_gnt),
      .p_gnt          (p_gnt),
      .d_rvalid       (d_rvalid),
      .p_rvalid       (p_rvalid),
      .r_last         (r_last),
      .rdata          (rdata),
      .d_hit_inflight (d_hit_inflight),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .mem_ready      (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected flag vector: {d_gnt, p_gnt, d_rvalid, p_rvalid, r_last, mem_req, d_hit_inflight}
   localparam logic [6:0] NO = 7'b0000000;
   localparam logic [6:0] DG = 7'b1000000;
   localparam logic [6:0] PG = 7'b0100000;
   localparam logic [6:0] DV = 7'b0010000;
   localparam logic [6:0] PV = 7'b0001000;
   localparam logic [6:0] RL = 7'b0000100;
   localparam logic [6:0] MQ = 7'b0000010;
   localparam logic [6:0] HT = 7'b0000001;

   typedef struct {
      string       name;
      logic        rst;
      logic        dr;
      logic [31:0] da;
      logic        pr;
      logic [31:0] pa;
      logic        pc;
      logic        mr;
      logic [31:0] md;
      logic [6:0]  ex;
      logic [31:0] ema;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(string nm, logic rst, logic dr, logic [31:0] da, logic pr,
                               logic [31:0] pa, logic pc, logic mr, logic [31:0] md,
                               logic [6:0] ex, logic [31:0] ema);
      vec_t v;
      v.name = nm; v.rst = rst; v.dr = dr; v.da = da; v.pr = pr; v.pa = pa;
      v.pc = pc; v.mr = mr; v.md = md; v.ex = ex; v.ema = ema;
      return v;
   endfunction

   task automatic check_vec(input vec_t v, input int idx);
      logic [6:0] act;
      act = {d_gnt, p_gnt, d_rvalid, p_rvalid, r_last, mem_req, d_hit_inflight};
      n_checks++;
      if (act !== v.ex) begin
         n_fail++;
         $display("FAIL %s[%0d] flags {dg,pg,dv,pv,rl,mq,hit}: got %b expected %b",
                  v.name, idx, act, v.ex);
      end
      n_checks++;
      if (mem_addr !== v.ema) begin
         n_fail++;
         $display("FAIL %s[%0d] mem_addr: got %h expected %h", v.name, idx, mem_addr, v.ema);
      end
      if (v.ex[4] || v.ex[3]) begin
         n_checks++;
         if (rdata !== v.md) begin
            n_fail++;
            $display("FAIL %s[%0d] rdata: got %h expected %h", v.name, idx, rdata, v.md);
         end
      end
   endtask

   initial begin
      int ngr;
      reset = 1'b1; d_req = 1'b0; d_addr = '0; p_req = 1'b0; p_addr = '0;
      p_cancel = 1'b0; mem_ready = 1'b0; mem_data = '0;

      // reset, dr, da, pr, pa, pc, mr, md, expected flags, expected mem_addr
      vq.push_back(mk("reset",  1, 1, 32'h00010008, 1, 32'h0, 1, 1, 32'h0, NO, 32'h0));
      vq.push_back(mk("reset",  1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, NO, 32'h0));
      // single demand burst
      vq.push_back(mk("dburst", 0, 1, 32'h00010008, 0, 32'h0, 0, 0, 32'h0, DG, 32'h0));
      vq.push_back(mk("dburst", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hDEAD0000, MQ, 32'h00010008));
      vq.push_back(mk("dburst", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hA0000000, DV, 32'h00010008));
      vq.push_back(mk("dburst", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, NO, 32'h00010008));
      vq.push_back(mk("dburst", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hA0000001, DV, 32'h00010008));
      vq.push_back(mk("dburst", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hA0000002, DV, 32'h00010008));
      vq.push_back(mk("dburst", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hA0000003, DV|RL, 32'h00010008));
      vq.push_back(mk("idle_rdy", 0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h0, NO, 32'h00010008));
      // both request: demand first, prefetch right after; cancel ignored for demand owner
      vq.push_back(mk("both",   0, 1, 32'h00020000, 1, 32'h00010010, 0, 0, 32'h0, DG, 32'h00010008));
      vq.push_back(mk("both",   0, 0, 32'h0, 1, 32'h00010010, 1, 1, 32'h0, MQ, 32'h00020000));
      vq.push_back(mk("both",   0, 1, 32'h00020000, 1, 32'h00010010, 1, 1, 32'hB0000000, DV, 32'h00020000));
      vq.push_back(mk("both",   0, 0, 32'h0, 1, 32'h00010010, 0, 1, 32'hB0000001, DV, 32'h00020000));
      vq.push_back(mk("both",   0, 0, 32'h0, 1, 32'h00010010, 1, 1, 32'hB0000002, DV, 32'h00020000));
      vq.push_back(mk("both",   0, 0, 32'h0, 1, 32'h00010010, 0, 1, 32'hB0000003, DV|RL, 32'h00020000));
      vq.push_back(mk("pgrant", 0, 0, 32'h0, 1, 32'h00010010, 0, 0, 32'h0, PG, 32'h00020000));
      // prefetch in flight: hit detection, then cancel after the first beat
      vq.push_back(mk("hit",    0, 0, 32'h0001001C, 0, 32'h0, 0, 0, 32'h0, MQ|HT, 32'h00010010));
      vq.push_back(mk("hit",    0, 0, 32'h00010020, 0, 32'h0, 0, 1, 32'hC0000000, PV, 32'h00010010));
      vq.push_back(mk("cancel", 0, 0, 32'h0001001C, 0, 32'h0, 1, 0, 32'h0, HT, 32'h00010010));
      vq.push_back(mk("cancel", 0, 0, 32'h0001001C, 0, 32'h0, 0, 1, 32'hC0000001, HT, 32'h00010010));
      vq.push_back(mk("cancel", 0, 1, 32'h00010014, 0, 32'h0, 0, 1, 32'hC0000002, HT, 32'h00010010));
      vq.push_back(mk("cancel", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hC0000003, NO, 32'h00010010));
      vq.push_back(mk("cancel", 0, 0, 32'h0001001C, 0, 32'h0, 0, 1, 32'h0, NO, 32'h00010010));
      // demand burst interrupted by reset after the second beat
      vq.push_back(mk("rstmid", 0, 1, 32'h00030000, 0, 32'h0, 0, 0, 32'h0, DG, 32'h00010010));
      vq.push_back(mk("rstmid", 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, MQ, 32'h00030000));
      vq.push_back(mk("rstmid", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hD0000000, DV, 32'h00030000));
      vq.push_back(mk("rstmid", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hD0000001, DV, 32'h00030000));
      vq.push_back(mk("rstmid", 1, 1, 32'h00030000, 1, 32'h0, 0, 1, 32'hD0000002, NO, 32'h0));
      vq.push_back(mk("rstmid", 0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hD0000003, NO, 32'h0));
      vq.push_back(mk("after",  0, 1, 32'h00040000, 0, 32'h0, 0, 0, 32'h0, DG, 32'h0));
      vq.push_back(mk("after",  0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, MQ, 32'h00040000));
      vq.push_back(mk("after",  0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hE0000000, DV, 32'h00040000));
      vq.push_back(mk("after",  0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hE0000001, DV, 32'h00040000));
      vq.push_back(mk("after",  0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hE0000002, DV, 32'h00040000));
      vq.push_back(mk("after",  0, 0, 32'h0, 0, 32'h0, 0, 1, 32'hE0000003, DV|RL, 32'h00040000));

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         reset = vq[i].rst; d_req = vq[i].dr; d_addr = vq[i].da; p_req = vq[i].pr;
         p_addr = vq[i].pa; p_cancel = vq[i].pc; mem_ready = vq[i].mr; mem_data = vq[i].md;
         #1;
         check_vec(vq[i], i);
      end

      // Continuous contention: grants must rotate D,D,D,P twice, proving the counter clears.
      @(negedge clk);
      reset = 1'b0; d_req = 1'b1; d_addr = 32'h00050000; p_req = 1'b1;
      p_addr = 32'h00060000; p_cancel = 1'b0; mem_ready = 1'b1; mem_data = 32'h0;
      ngr = 0;
      for (int cyc = 0; cyc < 100 && ngr < 8; cyc++) begin
         #1;
         if (d_gnt || p_gnt) begin
            n_checks++;
            if ({d_gnt, p_gnt} !== ((ngr % 4 == 3) ? 2'b01 : 2'b10)) begin
               n_fail++;
               $display("FAIL starve grant %0d: got {dg,pg}=%b expected %b", ngr,
                        {d_gnt, p_gnt}, (ngr % 4 == 3) ? 2'b01 : 2'b10);
            end
            ngr++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (ngr != 8) begin
         n_fail++;
         $display("FAIL starve timeout: got %0d grants expected 8", ngr);
      end

      d_req = 1'b0; p_req = 1'b0; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ucsbece154_imem_arb.md
UCSBECE154_IMEM_ARB -- requirements
Module: ucsbece154_imem_arb

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 4: data beats per memory burst; must be a power of two, at least 2.
REQ-002 SHALL have parameter STARVE_LIMIT, default 3: consecutive demand grants allowed while prefetch waits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port d_req  input  1  demand (cache miss) request, held until d_gnt.
REQ-006 SHALL have port d_addr  input  32  demand word address, stable while d_req high.
REQ-007 SHALL have port p_req  input  1  prefetch request, held until p_gnt or withdrawn.
REQ-008 SHALL have port p_addr  input  32  prefetch word address.
REQ-009 SHALL have port p_cancel  input  1  drop in-flight prefetch data delivery.
REQ-010 SHALL have port d_gnt / p_gnt  output  1 each  one-cycle grant pulse.
REQ-011 SHALL have port d_rvalid / p_rvalid  output  1 each  beat valid to owner.
REQ-012 SHALL have port r_last  output  1  final beat of burst.
REQ-013 SHALL have port rdata  output  32  beat data, shared by both owners.
REQ-014 SHALL have port d_hit_inflight  output  1  d_addr block equals in-flight prefetch block.
REQ-015 SHALL have port mem_req  output  1  one-cycle read request to instruction memory.
REQ-016 SHALL have port mem_addr  output  32  address for mem_req, held for the whole burst.
REQ-017 SHALL have port mem_data  input  32  memory beat data.
REQ-018 SHALL have port mem_ready  input  1  memory beat valid.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> BURST -> IDLE.
REQ-020 IDLE: any request present SHALL select a winner, pulse its gnt, latch its address and owner, and move to ISSUE on the same edge.
REQ-021 Arbitration SHALL be fixed demand priority, except prefetch wins when the starvation counter equals STARVE_LIMIT and p_req is high.
REQ-022 Starvation counter SHALL increment on a demand grant while p_req is high, saturate at STARVE_LIMIT, and clear on a prefetch grant or when p_req is low.
REQ-023 ISSUE SHALL assert mem_req for exactly one cycle with mem_addr = latched address, then enter BURST.
REQ-024 BURST SHALL count mem_ready beats with a log2(BLOCK_WORDS)-bit counter; each beat forwards mem_data to rdata and pulses the owner's rvalid in the same cycle (combinational pass-through, zero added latency).
REQ-025 On beat BLOCK_WORDS, r_last SHALL pulse with the final rvalid, the counter SHALL wrap to 0, and the FSM SHALL return to IDLE; a new grant is possible the following cycle.
REQ-026 Requests arriving outside IDLE SHALL NOT be granted; mem_req SHALL never assert outside ISSUE.
REQ-027 d_hit_inflight SHALL be high when the owner is prefetch, the FSM is in ISSUE or BURST, and d_addr[31:4] equals the latched address[31:4], regardless of d_req.
REQ-028 p_cancel in ISSUE or BURST with owner prefetch SHALL suppress p_rvalid and r_last for the remainder of that burst; the burst SHALL still be counted to completion (memory cannot abort).
REQ-029 p_cancel with owner demand or in IDLE SHALL have no effect.
REQ-030 mem_ready in IDLE or ISSUE SHALL be ignored, with no rvalid.
REQ-031 Simultaneous d_req and p_req with counter below limit SHALL grant demand only; p_req stays pending.

Reset
REQ-032 On reset the FSM SHALL go to IDLE, with beat counter, starvation counter, owner, cancel flag and latched address cleared to 0.
REQ-033 During reset, mem_req, d_gnt, p_gnt, d_rvalid, p_rvalid, r_last and d_hit_inflight SHALL be 0; mem_addr SHALL be 0.
REQ-034 Reset mid-burst SHALL abandon the burst with no further rvalid; the memory is reset by the same signal.

Verification
REQ-035 d_req=1, d_addr=0x00010008: d_gnt pulse; mem_req pulse next cycle with mem_addr=0x00010008; 4 mem_ready beats give 4 d_rvalid, r_last on the 4th.
REQ-036 d_req and p_req both high in IDLE, counter 0: d_gnt only; after the burst ends, p_gnt is granted next cycle.
REQ-037 d_req always high with p_req high: grants are D,D,D,P (STARVE_LIMIT=3), then the counter is 0.
REQ-038 Prefetch burst of 0x00010010 in flight, d_addr=0x0001001C: d_hit_inflight=1; d_addr=0x00010020 gives 0.
REQ-039 p_cancel after the 1st prefetch beat: no further p_rvalid or r_last; IDLE after the 4th mem_ready; the next grant works.
REQ-040 reset asserted after the 2nd beat: all outputs 0 next cycle; a following d_req is granted normally.
